// File: rtl/wb_cmd_master.sv
// Wishbone classic master: a FIFO of queued register commands, one bus cycle per command.
// Define WB_TIMEOUT_EN to end a cycle with an error when the slave never terminates it.
module wb_cmd_master #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8,
  parameter int SEL_W       = DATA_W / 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [DATA_W-1:0] cmd_dat,
  input  logic [SEL_W-1:0]  cmd_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_dat,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] wbs_adr_i,
  output logic [DATA_W-1:0] wbs_dat_i,
  input  logic [DATA_W-1:0] wbs_dat_o,
  output logic [SEL_W-1:0]  wbs_sel_i,
  output logic              wbs_we_i,
  output logic              wbs_stb_i,
  output logic              wbs_cyc_i,
  input  logic              wbs_ack_o,
  input  logic              wbs_err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = 1 + ADDR_W + DATA_W + SEL_W;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t            state;
  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop;
  logic              h_we;
  logic [ADDR_W-1:0] h_adr;
  logic [DATA_W-1:0] h_dat;
  logic [SEL_W-1:0]  h_sel;

`ifdef WB_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TMO_W-1:0] tmo;
`endif

  assign cmd_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == IDLE) & (count != '0);
  assign busy      = (state != IDLE) | (count != '0);
  assign {h_we, h_adr, h_dat, h_sel} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_we, cmd_adr, cmd_dat, cmd_sel};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      wbs_adr_i <= '0;
      wbs_dat_i <= '0;
      wbs_sel_i <= '0;
      wbs_we_i  <= 1'b0;
      wbs_stb_i <= 1'b0;
      wbs_cyc_i <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
`ifdef WB_TIMEOUT_EN
      tmo       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            wbs_adr_i <= h_adr;
            wbs_dat_i <= h_dat;
            wbs_sel_i <= h_sel;
            wbs_we_i  <= h_we;
            wbs_stb_i <= 1'b1;
            wbs_cyc_i <= 1'b1;
            state     <= BUS;
`ifdef WB_TIMEOUT_EN
            tmo       <= '0;
`endif
          end
        end
        BUS: begin
          if (wbs_err_o) begin
            wbs_stb_i <= 1'b0;
            wbs_cyc_i <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wbs_ack_o) begin
            wbs_stb_i <= 1'b0;
            wbs_cyc_i <= 1'b0;
            rsp_dat   <= wbs_we_i ? '0 : wbs_dat_o;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`ifdef WB_TIMEOUT_EN
          // tmo counts completed BUS cycles, so this fires on cycle TIMEOUT_CYC
          else if (tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
            wbs_stb_i <= 1'b0;
            wbs_cyc_i <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            tmo <= tmo + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
